// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: sequences delay-line writes, coefficient reads and MAC control for one FIR output per input sample
// Ports: iClk12M/iRst clock and async reset; iEnSample600k new-sample strobe; iCoeffUpdateFlag/iAddrRam
// coefficient update request and address; iNumOfCoeff tap count; iClrOvr clears oOverrun.
// oDly* delay-line write/read control, oCoeff* coefficient RAM control, oMacClr/oMacEn/oOutLatch
// accumulator control, oBusy non-idle indicator, oOverrun sticky dropped-sample flag.
module fir_tap_scheduler #(
   parameter int MAX_TAPS = 32,
   parameter int DLY_AW   = 5
) (
   input  logic              iClk12M,
   input  logic              iRst,
   input  logic              iEnSample600k,
   input  logic              iCoeffUpdateFlag,
   input  logic [5:0]        iAddrRam,
   input  logic [5:0]        iNumOfCoeff,
   input  logic              iClrOvr,
   output logic              oDlyWrEn,
   output logic [DLY_AW-1:0] oDlyWrAddr,
   output logic [DLY_AW-1:0] oDlyRdAddr,
   output logic [5:0]        oCoeffAddr,
   output logic              oCoeffWrEn,
   output logic              oCoeffRdEn,
   output logic              oMacClr,
   output logic              oMacEn,
   output logic              oOutLatch,
   output logic              oBusy,
   output logic              oOverrun
);
   typedef enum logic [2:0] {IDLE, UPDATE, LOAD, MAC, DRAIN, DONE} state_t;
   localparam logic [6:0] MAX7 = 7'(MAX_TAPS);
   state_t            state_q, state_d;
   logic [DLY_AW-1:0] wp_q, wp_d, k_q, k_d;
   logic [DLY_AW:0]   neff_q, neff_d;
   logic              mac_en_q, mac_en_d, ovr_q, ovr_d;
   logic [6:0]        n_req;
   logic              last_k;
   assign n_req  = {1'b0, iNumOfCoeff};
   assign last_k = {1'b0, k_q} == neff_q - 1'b1;
   always_comb begin
      state_d  = state_q;
      wp_d     = wp_q;
      k_d      = k_q;
      neff_d   = neff_q;
      // product of the read issued in a MAC cycle arrives one cycle later
      mac_en_d = state_q == MAC;
      ovr_d    = (iEnSample600k && state_q != IDLE && state_q != UPDATE) ? 1'b1 : iClrOvr ? 1'b0 : ovr_q;
      case (state_q)
         IDLE: begin
            if (iCoeffUpdateFlag) state_d = UPDATE;
            else if (iEnSample600k) begin
               state_d = LOAD;
               k_d     = '0;
               neff_d  = (DLY_AW+1)'(n_req > MAX7 ? MAX7 : n_req);
            end
         end
         UPDATE: state_d = iCoeffUpdateFlag ? UPDATE : IDLE;
         LOAD:   state_d = neff_q == '0 ? DONE : MAC;
         MAC: begin
            k_d     = last_k ? '0 : k_q + 1'b1;
            state_d = last_k ? DRAIN : MAC;
         end
         DRAIN:  state_d = DONE;
         DONE: begin
            wp_d    = wp_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         state_q  <= IDLE;
         wp_q     <= '0;
         k_q      <= '0;
         neff_q   <= '0;
         mac_en_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wp_q     <= wp_d;
         k_q      <= k_d;
         neff_q   <= neff_d;
         mac_en_q <= mac_en_d;
         ovr_q    <= ovr_d;
      end
   end
   assign oDlyWrEn   = state_q == LOAD;
   assign oMacClr    = state_q == LOAD;
   assign oDlyWrAddr = wp_q;
   assign oCoeffRdEn = state_q == MAC;
   assign oDlyRdAddr = state_q == MAC ? wp_q - k_q : '0;
   // coefficient address passes straight through while an update is in progress
   assign oCoeffAddr = state_q == UPDATE ? iAddrRam : state_q == MAC ? 6'(k_q) : '0;
   assign oCoeffWrEn = state_q == UPDATE && iCoeffUpdateFlag && {1'b0, iAddrRam} < MAX7;
   assign oMacEn     = mac_en_q;
   assign oOutLatch  = state_q == DONE;
   assign oBusy      = state_q != IDLE;
   assign oOverrun   = ovr_q;
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb_fir_tap_scheduler: scoreboard bench with a cycle-timed event model of the tap scheduler
module tb_fir_tap_scheduler;
   logic       clk = 1'b0, iRst = 1'b1, iEnSample600k = 1'b0, iCoeffUpdateFlag = 1'b0, iClrOvr = 1'b0;
   logic [5:0] iAddrRam = '0, iNumOfCoeff = '0;
   logic       oDlyWrEn, oCoeffWrEn, oCoeffRdEn, oMacClr, oMacEn, oOutLatch, oBusy, oOverrun;
   logic [4:0] oDlyWrAddr, oDlyRdAddr;
   logic [5:0] oCoeffAddr;
   typedef struct packed {
      int         c;
      logic       we;
      logic [4:0] wa;
      logic       rd;
      logic [5:0] ca;
      logic [4:0] ra;
      logic       clr;
      logic       mac;
      logic       lat;
      logic       cw;
   } ev_t;
   ev_t q[$];
   int  ua[$];
   int  cyc = 0, n_chk = 0, n_bad = 0, free_at = 0, wp_m = 0;
   bit  ovr_m = 0;
   fir_tap_scheduler #(.MAX_TAPS(32), .DLY_AW(5)) dut (
      .iClk12M(clk), .iRst(iRst), .iEnSample600k(iEnSample600k), .iCoeffUpdateFlag(iCoeffUpdateFlag),
      .iAddrRam(iAddrRam), .iNumOfCoeff(iNumOfCoeff), .iClrOvr(iClrOvr), .oDlyWrEn(oDlyWrEn),
      .oDlyWrAddr(oDlyWrAddr), .oDlyRdAddr(oDlyRdAddr), .oCoeffAddr(oCoeffAddr), .oCoeffWrEn(oCoeffWrEn),
      .oCoeffRdEn(oCoeffRdEn), .oMacClr(oMacClr), .oMacEn(oMacEn), .oOutLatch(oOutLatch),
      .oBusy(oBusy), .oOverrun(oOverrun));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
   always @(negedge clk) begin
      ev_t g, e;
      if (!iRst && (oDlyWrEn || oCoeffRdEn || oMacEn || oOutLatch || oCoeffWrEn || oMacClr)) begin
         g = '{cyc, oDlyWrEn, oDlyWrAddr, oCoeffRdEn, oCoeffAddr, oDlyRdAddr, oMacClr, oMacEn, oOutLatch, oCoeffWrEn};
         n_chk++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL ev_unexpected got=%h", g);
         end else begin
            e = q.pop_front();
            if (g !== e) begin
               n_bad++;
               $display("FAIL ev cyc=%0d got=%h exp=%h", cyc, g, e);
            end
         end
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask
   function automatic void push(int c, bit we, bit rd, int ca, int ra, bit clr, bit mac, bit lat, bit cw, int wa);
      ev_t e;
      e.c = c; e.we = we; e.wa = 5'(wa); e.rd = rd; e.ca = 6'(ca); e.ra = 5'(ra);
      e.clr = clr; e.mac = mac; e.lat = lat; e.cw = cw;
      q.push_back(e);
   endfunction
   task automatic strobe(input int n);
      int c, ne, d, w;
      c = cyc;
      w = wp_m;
      iEnSample600k = 1'b1;
      iNumOfCoeff   = 6'(n);
      if (c >= free_at) begin
         ne = n > 32 ? 32 : n;
         push(c + 1, 1, 0, 0, 0, 1, 0, 0, 0, w);
         for (int k = 0; k < ne; k++) push(c + 2 + k, 0, 1, k, (w - k) & 31, 0, k > 0, 0, 0, w);
         if (ne > 0) push(c + ne + 2, 0, 0, 0, 0, 0, 1, 0, 0, w);
         d = ne > 0 ? c + ne + 3 : c + 2;
         push(d, 0, 0, 0, 0, 0, 0, 1, 0, w);
         free_at = d + 1;
         wp_m    = (w + 1) % 32;
      end else ovr_m = 1;
      tick;
      iEnSample600k = 1'b0;
      iNumOfCoeff   = 6'($urandom_range(0, 63));
   endtask
   task automatic update(input bit strobe_mid);
      int c, en;
      c = cyc;
      iCoeffUpdateFlag = 1'b1;
      en = c >= free_at ? c + 1 : free_at + 1;
      foreach (ua[i]) if (ua[i] < 32) push(en + i, 0, 0, ua[i], 0, 0, 0, 0, 1, wp_m);
      while (cyc < en) begin
         iAddrRam = 6'($urandom_range(0, 63));
         tick;
      end
      foreach (ua[i]) begin
         iAddrRam = 6'(ua[i]);
         iEnSample600k = strobe_mid && i == 1;
         tick;
      end
      iEnSample600k    = 1'b0;
      iCoeffUpdateFlag = 1'b0;
      iAddrRam         = 6'd3;
      tick;
      free_at = cyc;
      chk("upd_idle", 32'(oBusy), 0);
   endtask
   task automatic wait_idle;
      while (cyc < free_at) tick;
   endtask
   initial begin
      int c, n;
      repeat (3) tick;
      chk("rst_out", {oDlyWrEn, oDlyWrAddr, oDlyRdAddr, oCoeffAddr, oCoeffWrEn, oCoeffRdEn,
                      oMacClr, oMacEn, oOutLatch, oBusy, oOverrun}, 0);
      iRst = 1'b0;
      free_at = cyc;
      strobe(5);
      chk("busy_run", 32'(oBusy), 1);
      wait_idle;
      chk("idle_busy", 32'(oBusy), 0);
      chk("idle_wp", 32'(oDlyWrAddr), 32'(wp_m));
      chk("idle_caddr", 32'(oCoeffAddr), 0);
      chk("idle_raddr", 32'(oDlyRdAddr), 0);
      strobe(0);
      wait_idle;
      strobe(40);
      wait_idle;
      c = cyc;
      strobe(21);
      while (cyc < c + 20) tick;
      strobe(21);
      chk("ovr_set", 32'(oOverrun), 32'(ovr_m));
      while (cyc < c + 40) tick;
      strobe(21);
      chk("ovr_hold", 32'(oOverrun), 1);
      wait_idle;
      iClrOvr = 1'b1;
      tick;
      iClrOvr = 1'b0;
      ovr_m = 0;
      chk("ovr_clr", 32'(oOverrun), 0);
      strobe(8);
      iClrOvr = 1'b1;
      strobe(8);
      iClrOvr = 1'b0;
      chk("ovr_set_wins", 32'(oOverrun), 1);
      wait_idle;
      iClrOvr = 1'b1;
      tick;
      iClrOvr = 1'b0;
      ovr_m = 0;
      c = cyc;
      strobe(5);
      while (cyc < c + 4) tick;
      ua.delete();
      for (int i = 0; i < 24; i++) ua.push_back(i);
      ua.push_back(40);
      update(1);
      chk("upd_no_ovr", 32'(oOverrun), 0);
      c = cyc;
      strobe(10);
      while (cyc < c + 5) tick;
      iRst = 1'b1;
      #1;
      chk("rst_mid", {oDlyWrEn, oDlyWrAddr, oDlyRdAddr, oCoeffAddr, oCoeffWrEn, oCoeffRdEn,
                      oMacClr, oMacEn, oOutLatch, oOverrun}, 0);
      chk("rst_mid_busy", 32'(oBusy), 0);
      while (q.size() > 0 && q[$].c >= c + 5) void'(q.pop_back());
      iEnSample600k = 1'b1;
      tick;
      iEnSample600k = 1'b0;
      tick;
      iRst = 1'b0;
      wp_m = 0;
      ovr_m = 0;
      free_at = cyc;
      c = cyc;
      for (int i = 0; i < 33; i++) begin
         while (cyc < c + 40 * i) tick;
         strobe(1);
      end
      wait_idle;
      chk("wrap_no_ovr", 32'(oOverrun), 0);
      chk("wrap_wp", 32'(oDlyWrAddr), 32'(wp_m));
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 25)) tick;
         if ($urandom_range(0, 9) < 7) begin
            strobe($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(0, 3)) tick;
               strobe($urandom_range(0, 63));
            end
         end else begin
            ua.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) ua.push_back($urandom_range(0, 63));
            update($urandom_range(0, 1) == 1);
         end
         chk("ovr_rand", 32'(oOverrun), 32'(ovr_m));
         if ($urandom_range(0, 3) == 0) begin
            iClrOvr = 1'b1;
            tick;
            iClrOvr = 1'b0;
            ovr_m = 0;
         end
      end
      wait_idle;
      repeat (3) tick;
      chk("drain", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/fir_tap_scheduler.md
FIR_TAP_SCHEDULER -- requirements
Module: fir_tap_scheduler

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 32, meaning delay-line depth and maximum taps processed per sample (power of two).
REQ-002 SHALL have parameter DLY_AW, default 5, meaning delay-line address width (log2 MAX_TAPS).
REQ-003 iClk12M  in  1  12 MHz system clock; all state changes on its rising edge.
REQ-004 iRst  in  1  asynchronous, active-high reset.
REQ-005 iEnSample600k  in  1  one-cycle new-sample strobe, nominally every 20 clocks.
REQ-006 iCoeffUpdateFlag  in  1  coefficient-update request, level.
REQ-007 iAddrRam  in  6  coefficient write address during update.
REQ-008 iNumOfCoeff  in  6  number of taps N.
REQ-009 iClrOvr  in  1  clears oOverrun.
REQ-010 oDlyWrEn  out  1  write current input sample into delay line.
REQ-011 oDlyWrAddr  out  DLY_AW  delay-line write pointer wp.
REQ-012 oDlyRdAddr  out  DLY_AW  delay-line read address.
REQ-013 oCoeffAddr  out  6  coefficient RAM address.
REQ-014 oCoeffWrEn  out  1  coefficient RAM write enable.
REQ-015 oCoeffRdEn  out  1  coefficient RAM read enable.
REQ-016 oMacClr  out  1  clear accumulator.
REQ-017 oMacEn  out  1  accumulate product of RAM read data (1-cycle read latency).
REQ-018 oOutLatch  out  1  latch accumulator to filter output, one cycle.
REQ-019 oBusy  out  1  high in any state except IDLE.
REQ-020 oOverrun  out  1  sticky dropped-sample flag.

Function
REQ-021 SHALL implement a registered FSM with states IDLE, UPDATE, LOAD, MAC, DRAIN, DONE; outputs decoded from registered state/counters (Moore, plus UPDATE pass-through per REQ-030).
REQ-022 IDLE: iCoeffUpdateFlag=1 -> UPDATE (priority); else iEnSample600k=1 -> LOAD; else stay.
REQ-023 On LOAD entry SHALL capture Neff = min(iNumOfCoeff, MAX_TAPS); later iNumOfCoeff changes ignored until next sample.
REQ-024 LOAD (1 cycle): oDlyWrEn=1, oDlyWrAddr=wp, oMacClr=1; next MAC if Neff>0, else DONE.
REQ-025 MAC (Neff cycles, k=0..Neff-1): oCoeffRdEn=1, oCoeffAddr=k, oDlyRdAddr=(wp-k) mod MAX_TAPS; after k=Neff-1 -> DRAIN.
REQ-026 oMacEn SHALL be high exactly one cycle after each MAC cycle, i.e. MAC cycles 2..Neff and the DRAIN cycle; never otherwise.
REQ-027 DRAIN (1 cycle) -> DONE; DONE (1 cycle): oOutLatch=1, wp <= (wp+1) mod MAX_TAPS, -> IDLE.
REQ-028 Strobe cycle = 0: LOAD cycle 1, MAC cycles 2..Neff+1, DRAIN Neff+2, DONE Neff+3; Neff=0: DONE cycle 2.
REQ-029 iEnSample600k in any state except IDLE/UPDATE SHALL be dropped and set oOverrun; strobe in UPDATE dropped without setting oOverrun.
REQ-030 UPDATE: oCoeffAddr=iAddrRam; oCoeffWrEn=1 when iCoeffUpdateFlag=1 and iAddrRam<MAX_TAPS; flag low -> IDLE (oCoeffWrEn low that cycle).
REQ-031 iCoeffUpdateFlag raised while busy SHALL be deferred until the DONE->IDLE return; computation never aborted.
REQ-032 oOverrun: set wins over iClrOvr in same cycle.
REQ-033 All address arithmetic SHALL wrap modulo MAX_TAPS; wp unchanged by UPDATE.
REQ-034 When no state above asserts an output, it SHALL be 0 (oDlyWrAddr always = wp; oCoeffAddr/oDlyRdAddr 0).

Reset
REQ-035 iRst=1 SHALL immediately force IDLE, wp=0, k=0, oOverrun=0 and every output to 0, including mid-computation or mid-update.
REQ-036 First rising edge after iRst falls SHALL evaluate IDLE transitions normally; a pre-release strobe is lost.

Verification
REQ-037 Reset mid-MAC (N=10, cycle 5) -> all outputs 0 same cycle, oBusy=0, next strobe reads from wp=0.
REQ-038 wp=0, N=5, strobe cycle 0 -> oDlyWrEn cycle 1; oCoeffAddr 0..4 / oDlyRdAddr 0,31,30,29,28 cycles 2..6; oMacEn cycles 3..7; oOutLatch cycle 8; wp=1.
REQ-039 N=21, strobes every 20 cycles -> second strobe (cycle 20, MAC) dropped, oOverrun=1; third strobe (cycle 40) accepted; iClrOvr clears.
REQ-040 Update flag raised at cycle 4 of N=5 run -> UPDATE entered after cycle 8; writes addr 0..23 pulse oCoeffWrEn; addr 40 no write.
REQ-041 N=0 -> LOAD, DONE cycle 2, no oMacEn, oOutLatch once; N=40 -> Neff=32, DONE cycle 35.
REQ-042 33 consecutive N=1 samples at 40-cycle spacing -> oDlyWrAddr 0..31 then 0 (wrap), no overrun.
